// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX pipeline definitions: widths, control bundle
// and the operand-read rules also used by forwarding.
package id_ex_stage_pkg;

    localparam int XLEN    = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 4;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluOp;
        logic               isAuipc;
        logic               aluSrc;
        logic               memWrite;
        logic               memRead;
        logic               regWr;
    } idExCtrl_t;

    function automatic logic rs1Read(
        input logic             isAuipc,
        input logic [REG_W-1:0] rs1
    );
        return ~isAuipc & (rs1 != '0);
    endfunction

    // Stores read rs2 even though the ALU takes the immediate
    function automatic logic rs2Read(
        input logic             aluSrc,
        input logic             memWrite,
        input logic [REG_W-1:0] rs2
    );
        return (~aluSrc | memWrite) & (rs2 != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the load in EX and the
// instruction in ID.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             exValid,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRd,
    input  logic             idValid,
    input  logic [REG_W-1:0] idRs1,
    input  logic [REG_W-1:0] idRs2,
    input  logic             idIsAuipc,
    input  logic             idAluSrc,
    input  logic             idMemWrite,
    output logic             loadUse
);

    logic useRs1;
    logic useRs2;

    always_comb begin
        useRs1 = rs1Read(idIsAuipc, idRs1) & (idRs1 == exRd);
        useRs2 = rs2Read(idAluSrc, idMemWrite, idRs2) & (idRs2 == exRd);
        loadUse = exValid & exMemRead & (exRd != '0) & idValid
                & (useRs1 | useRs2);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// flush, downstream stall and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = id_ex_stage_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rdata1,
    input  logic [XLEN-1:0] id_rdata2,
    input  logic [3:0]      id_aluop,
    input  logic            id_is_auipc,
    input  logic            id_alusrc,
    input  logic            id_memwrite,
    input  logic            id_memread,
    input  logic            id_regwr,
    input  logic            flush,
    input  logic            mem_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [3:0]      ex_aluop,
    output logic            ex_is_auipc,
    output logic            ex_alusrc,
    output logic            ex_memwrite,
    output logic            ex_memread,
    output logic            ex_regwr,
    output logic            id_stall,
    output logic [31:0]     bubble_cnt
);

    idExCtrl_t idCtrl;
    idExCtrl_t exCtrl;
    logic      loadUse;
    logic      insertBubble;

    hazard_detect uHazard (
        .exValid    (ex_valid),
        .exMemRead  (exCtrl.memRead),
        .exRd       (ex_rd),
        .idValid    (id_valid),
        .idRs1      (id_rs1),
        .idRs2      (id_rs2),
        .idIsAuipc  (id_is_auipc),
        .idAluSrc   (id_alusrc),
        .idMemWrite (id_memwrite),
        .loadUse    (loadUse)
    );

    // An invalid instruction never carries live side effects
    always_comb begin
        idCtrl.aluOp    = id_aluop;
        idCtrl.isAuipc  = id_is_auipc;
        idCtrl.aluSrc   = id_alusrc;
        idCtrl.memWrite = id_memwrite & id_valid;
        idCtrl.memRead  = id_memread & id_valid;
        idCtrl.regWr    = id_regwr & id_valid;
    end

    assign insertBubble = ~mem_stall & ~flush & loadUse;
    assign id_stall     = mem_stall | (~flush & loadUse);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_imm    <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            exCtrl    <= '0;
        end else if (!mem_stall) begin
            if (flush || loadUse) begin
                ex_valid        <= 1'b0;
                exCtrl.memWrite <= 1'b0;
                exCtrl.memRead  <= 1'b0;
                exCtrl.regWr    <= 1'b0;
            end else begin
                ex_valid  <= id_valid;
                ex_pc     <= id_pc;
                ex_rs1    <= id_rs1;
                ex_rs2    <= id_rs2;
                ex_rd     <= id_rd;
                ex_imm    <= id_imm;
                ex_rdata1 <= id_rdata1;
                ex_rdata2 <= id_rdata2;
                exCtrl    <= idCtrl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (insertBubble && bubble_cnt != 32'hFFFF_FFFF) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign ex_aluop    = exCtrl.aluOp;
    assign ex_is_auipc = exCtrl.isAuipc;
    assign ex_alusrc   = exCtrl.aluSrc;
    assign ex_memwrite = exCtrl.memWrite;
    assign ex_memread  = exCtrl.memRead;
    assign ex_regwr    = exCtrl.regWr;

endmodule
